// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl -- control FSM for one radix-2 single-path delay-feedback
// FFT stage. It sequences the delay line through fill (WAITING), first
// butterfly half (FIRST) and drain (SECOND). It also generates the
// shift-enable, the twiddle ROM address and the block-done pulse.
//
// Optional feature: define SDF_BLK_CNT_EN to add an 8-bit blk_cnt output.
// blk_cnt counts completed blocks and wraps from 255 to 0.
module sdf_stage_ctrl #(
  parameter int DEPTH     = 16,
  parameter int TW_STRIDE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] bf_state,
  output logic       sr_shift,
  output logic [3:0] tw_addr,
  output logic       out_valid,
  output logic       blk_done
`ifdef SDF_BLK_CNT_EN
  ,
  output logic [7:0] blk_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FIRST   = 2'b01,
    SECOND  = 2'b10,
    WAITING = 2'b11
  } state_t;

  localparam int             CW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEPTH - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last;

  assign accept   = in_valid & in_ready;
  assign last     = (cnt == CNT_LAST);
  assign bf_state = state;

  // Output decode: a pure function of state, cnt and in_valid.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
    in_ready  = 1'b0;
    sr_shift  = 1'b0;
    out_valid = 1'b0;
    tw_addr   = 4'd0;
    blk_done  = 1'b0;
    case (state)
      WAITING: begin
        in_ready = 1'b1;
        sr_shift = in_valid;
      end
      FIRST: begin
        in_ready  = 1'b1;
        sr_shift  = in_valid;
        out_valid = in_valid;
      end
      SECOND: begin
        sr_shift  = 1'b1;
        out_valid = 1'b1;
        tw_addr   = 4'((int'(cnt) * TW_STRIDE) % 16);
        blk_done  = last;
      end
      default: ;
    endcase
  end

  // Phase sequencing: state and in-phase sample counter.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= WAITING;
            cnt   <= '0;
          end
        end
        WAITING: begin
          if (accept) begin
            if (last) begin
              state <= FIRST;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        FIRST: begin
          if (accept) begin
            if (last) begin
              state <= SECOND;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        SECOND: begin
          if (last) begin
            state <= WAITING;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef SDF_BLK_CNT_EN
  // Completed-block counter; wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (rst) blk_cnt <= 8'd0;
    else if (blk_done) blk_cnt <= blk_cnt + 8'd1;
  end
`endif

endmodule
